// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter, its memory and its bench.
package dmem_pkg;

    // Arbiter FSM: accept a request, strobe the memory, wait out the latency, respond.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dmem_arb_state_t;

    // Requester identity: port 0 is the pipeline MEM stage, port 1 the debug/loader.
    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    // Default memory geometry and read latency.
    localparam int DMEM_DEPTH   = 256;
    localparam int DMEM_MEM_LAT = 1;

    // Latency counter width; covers MEM_LAT up to 15.
    localparam int DMEM_CNT_W   = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: a lone requester wins, a tie goes to the
// port that was not granted last.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_id,
    output logic [1:0] gnt,
    output logic       win_id
);

    // Choose the winner and its one-hot grant.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        win_id = PORT0;
        gnt    = 2'b00;
        if (req0 && req1) begin
            win_id = ~last_id;
        end else if (req1) begin
            win_id = PORT1;
        end
        if (req0 || req1) begin
            gnt = (win_id == PORT1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin access controller that shares the single-ported data memory
// between the pipeline MEM stage (port 0) and the debug/loader port (port 1).
// One access at a time: grant, one-cycle strobe, fixed latency, response.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int MEM_LAT = DMEM_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Depth widened by one bit so the unsigned compare covers every address bit.
    localparam logic [ADDR_W:0]         DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [DMEM_CNT_W-1:0]   LAT_LOAD  = DMEM_CNT_W'(MEM_LAT);
    localparam logic [DMEM_CNT_W-1:0]   CNT_ONE   = DMEM_CNT_W'(1);

    dmem_arb_state_t         r_state;
    dmem_arb_state_t         w_state_nxt;
    port_id_t                r_port;
    port_id_t                r_last;
    logic                    r_we;
    logic                    r_err;
    logic                    r_mem_read;
    logic                    r_mem_write;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic [DATA_W-1:0]       r_rdata0;
    logic [DATA_W-1:0]       r_rdata1;
    logic [DMEM_CNT_W-1:0]   r_cnt;

    logic [1:0]              w_arb_gnt;
    port_id_t                w_win;
    logic                    w_accept;
    logic                    w_sel_we;
    logic [ADDR_W-1:0]       w_sel_addr;
    logic [DATA_W-1:0]       w_sel_wdata;
    logic                    w_in_range;
    logic                    w_cnt_last;

    rr_arb2 u_rr_arb2 (
        .req0    (req0),
        .req1    (req1),
        .last_id (r_last),
        .gnt     (w_arb_gnt),
        .win_id  (w_win)
    );

    // Requests are only considered in IDLE; reset also masks the combinational grant.
    assign w_accept    = (r_state == IDLE) && rst_n && (req0 || req1);
    assign gnt0        = w_accept && w_arb_gnt[0];
    assign gnt1        = w_accept && w_arb_gnt[1];

    assign w_sel_we    = (w_win == PORT1) ? we1    : we0;
    assign w_sel_addr  = (w_win == PORT1) ? addr1  : addr0;
    assign w_sel_wdata = (w_win == PORT1) ? wdata1 : wdata0;
    assign w_in_range  = ({1'b0, w_sel_addr} < DEPTH_EXT);
    assign w_cnt_last  = (r_cnt == CNT_ONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = ISSUE;
            ISSUE:                   w_state_nxt = WAIT;
            WAIT:    if (w_cnt_last) w_state_nxt = RESP;
            RESP:                    w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // Latch the winning request and raise its strobe for the ISSUE cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port      <= PORT0;
            r_last      <= PORT1;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (w_accept) begin
                r_port      <= w_win;
                r_last      <= w_win;
                r_we        <= w_sel_we;
                r_err       <= !w_in_range;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_mem_read  <= w_in_range && !w_sel_we;
                r_mem_write <= w_in_range &&  w_sel_we;
            end
        end
    end

    // Latency counter: loaded leaving ISSUE, counts down through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= LAT_LOAD;
        end else if ((r_state == WAIT) && !w_cnt_last) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    // Read results: capture mem_rdata on the last WAIT edge for in-range reads only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if ((r_state == WAIT) && w_cnt_last && !r_we && !r_err) begin
            if (r_port == PORT1) begin
                r_rdata1 <= mem_rdata;
            end else begin
                r_rdata0 <= mem_rdata;
            end
        end
    end

    assign done0     = (r_state == RESP) && (r_port == PORT0);
    assign done1     = (r_state == RESP) && (r_port == PORT1);
    assign err0      = done0 && r_err;
    assign err1      = done1 && r_err;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT 1 and 4), each with its own
// latency-accurate memory, checked against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req0 [2], req1 [2], we0 [2], we1 [2];
    logic [31:0] addr0 [2], addr1 [2], wdata0 [2], wdata1 [2];
    logic        gnt0 [2], gnt1 [2], done0 [2], done1 [2], err0 [2], err1 [2];
    logic [31:0] rdata0 [2], rdata1 [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
    logic        mem_read [2], mem_write [2];

    logic [31:0] model_mem [2][256];
    logic [31:0] model_rd  [2][2];
    int          errors = 0;
    int          checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(DMEM_DEPTH), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
        .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
        .err0(err0[0]), .err1(err1[0]), .rdata0(rdata0[0]), .rdata1(rdata1[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0])
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(DMEM_DEPTH), .MEM_LAT(4)) dut_l4 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
        .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
        .err0(err0[1]), .err1(err1[1]), .rdata0(rdata0[1]), .rdata1(rdata1[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic logic [31:0] init_word(input int g, input int a);
        return 32'(a) * 32'h9E37_79B1 + 32'(g) * 32'h0001_0003 + 32'h0000_1234;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Memories: read data appears exactly L cycles after the strobe, junk otherwise.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        localparam int L = (g == 0) ? 1 : 4;
        logic [31:0]  wmem [256];
        logic [255:0] wval = '0;
        logic [31:0]  pipe [L];
        always @(posedge clk) begin
            if (mem_write[g]) begin
                wmem[mem_addr[g][7:0]] <= mem_wdata[g];
                wval[mem_addr[g][7:0]] <= 1'b1;
            end
            if (mem_read[g])
                pipe[0] <= wval[mem_addr[g][7:0]] ? wmem[mem_addr[g][7:0]]
                                                  : init_word(g, int'(mem_addr[g][7:0]));
            else
                pipe[0] <= $urandom;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[L-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_gnt(input int i, input bit p);
        return p ? gnt1[i] : gnt0[i];
    endfunction
    function automatic logic get_done(input int i, input bit p);
        return p ? done1[i] : done0[i];
    endfunction
    function automatic logic get_err(input int i, input bit p);
        return p ? err1[i] : err0[i];
    endfunction
    function automatic logic [31:0] get_rdata(input int i, input bit p);
        return p ? rdata1[i] : rdata0[i];
    endfunction

    task automatic drive(input int i, input bit p, input bit r, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            req1[i] = r; we1[i] = we; addr1[i] = a; wdata1[i] = d;
        end else begin
            req0[i] = r; we0[i] = we; addr0[i] = a; wdata0[i] = d;
        end
    endtask

    task automatic check_zero(input int i);
        chk($sformatf("i%0d rst ctl", i),
            {24'd0, gnt0[i], gnt1[i], done0[i], done1[i], err0[i], err1[i], mem_read[i], mem_write[i]}, 32'd0);
        chk($sformatf("i%0d rst rdata0", i), rdata0[i], 32'd0);
        chk($sformatf("i%0d rst rdata1", i), rdata1[i], 32'd0);
        chk($sformatf("i%0d rst mem_addr", i), mem_addr[i], 32'd0);
        chk($sformatf("i%0d rst mem_wdata", i), mem_wdata[i], 32'd0);
    endtask

    // One access from an idle arbiter; event cycles are counted from the grant cycle.
    task automatic access(input int i, input bit p, input bit we,
                          input logic [31:0] a, input logic [31:0] d);
        int L, g_cyc, st_cyc, dn_cyc, rd_n, wr_n, dn_n, other_n;
        bit oor, err_seen;
        logic [31:0] exp_rd, rd_at_done;
        string t;
        L = lat_of(i);
        oor = (a >= 32'd256);
        exp_rd = model_rd[i][p];
        if (!oor) begin
            if (we) model_mem[i][a[7:0]] = d;
            else    exp_rd = model_mem[i][a[7:0]];
        end
        model_rd[i][p] = exp_rd;
        g_cyc = -1; st_cyc = -1; dn_cyc = -1;
        rd_n = 0; wr_n = 0; dn_n = 0; other_n = 0;
        err_seen = 1'b0; rd_at_done = 32'd0;
        t = $sformatf("i%0d p%0d %s a=0x%0h", i, p, we ? "wr" : "rd", a);
        @(posedge clk); #1;
        drive(i, p, 1'b1, we, a, d);
        for (int c = 0; c < 4 + L; c++) begin
            @(negedge clk);
            if (get_gnt(i, p) && g_cyc < 0) g_cyc = c;
            if (get_gnt(i, !p) || get_done(i, !p) || get_err(i, !p)) other_n++;
            if (get_err(i, p) && !get_done(i, p)) other_n++;
            if (mem_read[i])  begin rd_n++; st_cyc = c; end
            if (mem_write[i]) begin wr_n++; st_cyc = c; end
            if (get_done(i, p)) begin
                dn_n++; dn_cyc = c;
                err_seen = get_err(i, p);
                rd_at_done = get_rdata(i, p);
            end
            if (get_gnt(i, p)) begin
                @(posedge clk); #1;
                drive(i, p, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        drive(i, p, 1'b0, 1'b0, 32'd0, 32'd0);
        chk({t, " gnt cycle"},    g_cyc, 0);
        chk({t, " read pulses"},  rd_n, (!oor && !we) ? 1 : 0);
        chk({t, " write pulses"}, wr_n, (!oor && we) ? 1 : 0);
        chk({t, " strobe cycle"}, st_cyc, oor ? -1 : 1);
        chk({t, " done pulses"},  dn_n, 1);
        chk({t, " done cycle"},   dn_cyc, 2 + L);
        chk({t, " err at done"},  32'(err_seen), 32'(oor));
        chk({t, " rdata at done"}, rd_at_done, exp_rd);
        chk({t, " rdata held"},   get_rdata(i, p), exp_rd);
        chk({t, " stray pulses"}, other_n, 0);
    endtask

    // Both requests held from cycle 0 (all reads); expects alternating grants 0,1,0,1.
    task automatic tie_run(input int i, input logic [31:0] a0, input logic [31:0] a1);
        int L, dn_n, bad;
        int gp [$];
        int gc [$];
        bit prev_strobe, dropped, p;
        logic [7:0] wa;
        L = lat_of(i);
        dn_n = 0; bad = 0; prev_strobe = 1'b0; dropped = 1'b0;
        for (int c = 0; c < 4 * (3 + L) + 3; c++) begin
            @(negedge clk);
            if (gnt0[i] && gnt1[i]) bad++;
            if (mem_read[i] && mem_write[i]) bad++;
            if ((mem_read[i] || mem_write[i]) && prev_strobe) bad++;
            prev_strobe = mem_read[i] || mem_write[i];
            if (gnt0[i] || gnt1[i]) begin
                gp.push_back(gnt1[i] ? 1 : 0);
                gc.push_back(c);
            end
            if (done0[i] || done1[i]) begin
                dn_n++;
                p = done1[i];
                if (done0[i] && done1[i]) bad++;
                if (gp.size() == 0) bad++;
                else if (int'(p) != gp[$] || c != gc[$] + 2 + L) bad++;
                wa = p ? a1[7:0] : a0[7:0];
                model_rd[i][p] = model_mem[i][wa];
                chk($sformatf("i%0d tie done%0d rdata", i, p), get_rdata(i, p), model_rd[i][p]);
            end
            if (gp.size() == 4 && !dropped) begin
                @(posedge clk); #1;
                req0[i] = 1'b0; req1[i] = 1'b0;
                dropped = 1'b1;
            end
        end
        req0[i] = 1'b0; req1[i] = 1'b0;
        chk($sformatf("i%0d tie grant count", i), gp.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("i%0d tie grant%0d port", i, k), (k < gp.size()) ? gp[k] : -1, k % 2);
            chk($sformatf("i%0d tie grant%0d cycle", i, k), (k < gc.size()) ? gc[k] : -1, k * (3 + L));
        end
        chk($sformatf("i%0d tie done count", i), dn_n, 4);
        chk($sformatf("i%0d tie protocol", i), bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ta0, ta1, ra;
        bit rp, rwe;
        int sel, n_bad;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            drive(i, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            model_rd[i][0] = 32'd0;
            model_rd[i][1] = 32'd0;
            for (int a = 0; a < 256; a++) model_mem[i][a] = init_word(i, a);
        end

        // Reset state, with both requests already held on instance 0.
        ta0 = $urandom_range(0, 255);
        ta1 = $urandom_range(0, 255);
        drive(0, 1'b0, 1'b1, 1'b0, ta0, 32'd0);
        drive(0, 1'b1, 1'b1, 1'b0, ta1, 32'd0);
        repeat (3) @(negedge clk);
        check_zero(0);
        check_zero(1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tie_run(0, ta0, ta1);

        // Directed accesses, MEM_LAT = 1.
        access(0, 1'b0, 1'b1, 32'd7, 32'd7);
        access(0, 1'b0, 1'b0, 32'd7, 32'd0);
        access(0, 1'b1, 1'b0, 32'd3, 32'd0);
        access(0, 1'b1, 1'b1, 32'd20, 32'hDEAD_BEEF);
        access(0, 1'b1, 1'b0, 32'd20, 32'd0);
        access(0, 1'b0, 1'b0, 32'd256, 32'd0);
        access(0, 1'b0, 1'b1, 32'd255, 32'h1357_9BDF);
        access(0, 1'b0, 1'b0, 32'd255, 32'd0);
        access(0, 1'b1, 1'b1, 32'h8000_0014, 32'h0BAD_0BAD);
        access(0, 1'b1, 1'b0, 32'd20, 32'd0);

        // Directed accesses, MEM_LAT = 4.
        access(1, 1'b0, 1'b0, 32'd9, 32'd0);
        access(1, 1'b1, 1'b1, 32'd100, $urandom);
        access(1, 1'b1, 1'b0, 32'd100, 32'd0);
        access(1, 1'b0, 1'b0, 32'd300, 32'd0);

        // Randomized accesses on both instances.
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 12; n++) begin
                rp  = 1'($urandom_range(0, 1));
                rwe = 1'($urandom_range(0, 1));
                sel = $urandom_range(0, 7);
                case (sel)
                    0:       ra = 32'd256 + $urandom_range(0, 15);
                    1:       ra = $urandom | 32'h0001_0000;
                    2, 3, 4: ra = $urandom_range(0, 15);
                    default: ra = $urandom_range(0, 255);
                endcase
                access(i, rp, rwe, ra, $urandom);
            end
        end

        // Reset in WAIT on the MEM_LAT = 4 instance; last grant before reset was port 0.
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
        @(negedge clk);
        chk("i1 abort gnt0", 32'(gnt0[1]), 32'd1);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("i1 abort strobe", 32'(mem_read[1]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        ta0 = $urandom_range(0, 255);
        ta1 = $urandom_range(0, 255);
        drive(1, 1'b0, 1'b1, 1'b0, ta0, 32'd0);
        drive(1, 1'b1, 1'b1, 1'b0, ta1, 32'd0);
        rst_n = 1'b0;
        #1;
        check_zero(1);
        check_zero(0);
        for (int i = 0; i < 2; i++) begin
            model_rd[i][0] = 32'd0;
            model_rd[i][1] = 32'd0;
        end
        n_bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done0[1] || done1[1] || gnt0[1] || gnt1[1] || mem_read[1] || mem_write[1]) n_bad++;
        end
        chk("i1 quiet in reset", n_bad, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tie_run(1, ta0, ta1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
